// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: accepts a byte over valid/ready and walks the
// start/data/parity/stop phases, driving the TX mux select, serial bit and parity bit.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  ready,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        bit_cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    par_en_reg;
  logic                    accept;

  // STOP also accepts so that back-to-back frames need no idle gap.
  assign ready    = (state == IDLE) || (state == STOP);
  assign accept   = ready && Data_Valid;
  assign ser_data = data_reg[bit_cnt];

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    mux_sel      = 2'b11;
    case (state)
      IDLE, STOP: begin
        if (accept) begin
          state_next   = START;
          bit_cnt_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        mux_sel    = 2'b00;
        state_next = DATA;
      end
      DATA: begin
        mux_sel = 2'b01;
        if (bit_cnt == LAST_BIT) begin
          state_next   = par_en_reg ? PARITY : STOP;
          bit_cnt_next = '0;
        end else begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        mux_sel    = 2'b10;
        state_next = STOP;
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // busy lags the state by one cycle to line up with the registered TX mux output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_reg   <= '0;
      par_en_reg <= 1'b0;
      par_bit    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      if (accept) begin
        data_reg   <= P_DATA;
        par_en_reg <= PAR_EN;
        par_bit    <= PAR_TYP ? ~^P_DATA : ^P_DATA;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: a frame-level model queues per-cycle expectations
// on every accept, and an independent monitor compares them against the DUT each cycle.
module tb_uart_tx_fsm;

  localparam int W = 8;

  typedef struct {
    logic [1:0] sel;
    logic       dbit;
    logic       par;
  } rec_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         Data_Valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         ready;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;
  logic         busy;

  int   compared = 0;
  int   mismatched = 0;
  int   accepted_cnt = 0;
  rec_t exp_q[$];
  rec_t mon_rec;
  logic prev_active = 1'b0;

  uart_tx_fsm #(.DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ready     (ready),
    .mux_sel   (mux_sel),
    .ser_data  (ser_data),
    .par_bit   (par_bit),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s at %0t: got timeout, expected completion", name, $time);
  endtask

  // A frame is start, LSB-first data, optional parity, stop; parity from the set-bit count.
  function automatic void pushFrame(input logic [W-1:0] w, input logic en, input logic typ);
    rec_t r;
    logic p;
    p = (($countones(w) % 2) == 1) ^ typ;
    r.par  = p;
    r.sel  = 2'b00;
    r.dbit = w[0];
    exp_q.push_back(r);
    for (int i = 0; i < W; i++) begin
      r.sel  = 2'b01;
      r.dbit = w[i];
      exp_q.push_back(r);
    end
    if (en) begin
      r.sel  = 2'b10;
      r.dbit = w[0];
      exp_q.push_back(r);
    end
    r.sel  = 2'b11;
    r.dbit = w[0];
    exp_q.push_back(r);
  endfunction

  always @(posedge CLK) begin
    if (RST === 1'b1 && Data_Valid === 1'b1 && exp_q.size() == 0) begin
      pushFrame(P_DATA, PAR_EN, PAR_TYP);
      accepted_cnt++;
    end
  end

  always @(negedge RST) exp_q.delete();

  always @(posedge CLK) begin
    #1;
    if (RST !== 1'b1) begin
      checkOutput("rst_mux_sel", mux_sel, 2'b11);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_ready", ready, 1'b1);
      prev_active = 1'b0;
    end else if (exp_q.size() > 0) begin
      mon_rec = exp_q.pop_front();
      checkOutput("mux_sel", mux_sel, mon_rec.sel);
      checkOutput("ready", ready, mon_rec.sel == 2'b11);
      checkOutput("busy", busy, prev_active);
      checkOutput("ser_data", ser_data, mon_rec.dbit);
      checkOutput("par_bit", par_bit, mon_rec.par);
      prev_active = 1'b1;
    end else begin
      checkOutput("idle_mux_sel", mux_sel, 2'b11);
      checkOutput("idle_ready", ready, 1'b1);
      checkOutput("idle_busy", busy, prev_active);
      prev_active = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [W-1:0] w, input logic en, input logic typ,
                               input bit hold_valid);
    int start_cnt;
    @(negedge CLK);
    P_DATA     = w;
    PAR_EN     = en;
    PAR_TYP    = typ;
    Data_Valid = 1'b1;
    start_cnt  = accepted_cnt;
    for (int i = 0; i < 40 && accepted_cnt == start_cnt; i++) @(negedge CLK);
    if (accepted_cnt == start_cnt) timeoutFail("accept_timeout");
    if (!hold_valid) Data_Valid = 1'b0;
    P_DATA  = W'($urandom);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) timeoutFail("drain_timeout");
    repeat (2) @(negedge CLK);
  endtask

  task automatic applyReset(input int cycles);
    RST = 1'b0;
    #2;
    checkOutput("async_rst_mux_sel", mux_sel, 2'b11);
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_ready", ready, 1'b1);
    checkOutput("async_rst_ser_data", ser_data, 1'b0);
    checkOutput("async_rst_par_bit", par_bit, 1'b0);
    repeat (cycles) @(negedge CLK);
    Data_Valid = 1'b0;
    RST = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog at %0t: got no finish, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit hold;
    #3;
    applyReset(2);
    repeat (20) @(negedge CLK);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
    waitIdle();
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
    waitIdle();
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    waitIdle();

    // Valid held high with a new word throughout the frame: taken only in STOP.
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    waitIdle();

    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    applyReset(2);
    repeat (20) @(negedge CLK);
    applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0);
    waitIdle();

    @(negedge CLK);
    P_DATA     = 8'h99;
    Data_Valid = 1'b1;
    applyReset(1);
    repeat (5) @(negedge CLK);

    for (int n = 0; n < 30; n++) begin
      hold = ($urandom_range(0, 3) == 0);
      applyStimulus(W'($urandom), 1'($urandom), 1'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    Data_Valid = 1'b0;
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
